// File: rtl/fifo_flags.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// sticky overflow/underflow errors and a selectable FWFT read mode.
module fifo_flags #(
  parameter int unsigned DataWidth         = 8,
  parameter int unsigned Depth             = 16,
  parameter int unsigned AlmostFullThresh  = Depth - 2,
  parameter int unsigned AlmostEmptyThresh = 2,
  parameter bit          Fwft              = 1'b0,
  localparam int unsigned CntWidth         = $clog2(Depth + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  output logic [DataWidth-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [CntWidth-1:0]  o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] AfLvl   = CntWidth'(AlmostFullThresh);
  localparam logic [CntWidth-1:0] AeLvl   = CntWidth'(AlmostEmptyThresh);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                wr_ok, rd_ok;

  assign o_count        = count_q;
  assign o_full         = (count_q == CntFull);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= AfLvl);
  assign o_almost_empty = (count_q <= AeLvl);
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

  // A full FIFO still takes a write when a pop frees a slot the same cycle.
  assign rd_ok = i_rd_en & ~o_empty;
  assign wr_ok = i_wr_en & (~o_full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // New errors take priority over a clear in the same cycle.
    ovf_d = (ovf_q & ~i_clr_err) | (i_wr_en & ~wr_ok);
    udf_d = (udf_q & ~i_clr_err) | (i_rd_en & ~rd_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_rst) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  if (Fwft) begin : g_fwft
    // Blank the head while empty so stale array contents never show.
    assign o_rd_data  = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_rd_valid = ~o_empty;
  end else begin : g_reg
    logic [DataWidth-1:0] rd_data_q;
    logic                 rd_valid_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) begin
          rd_data_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
  end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Synchronous single-clock FIFO, the parametrised successor to the team's basic `fifo`. It adds:
- arbitrary (non-power-of-two) depth;
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between UART byte producers and consumers (RX deserialiser to host, host to TX serialiser) wherever back-pressure thresholds are needed.

## Interface
- DataWidth, 8, word width in bits
- Depth, 16, number of storage words; any value ≥ 2, power of two not required
- AlmostFullThresh, Depth-2, o_almost_full asserts when count ≥ this value; legal range 1..Depth
- AlmostEmptyThresh, 2, o_almost_empty asserts when count ≤ this value; legal range 0..Depth-1
- Fwft, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- CntWidth (local), $clog2(Depth+1)
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_wr_en  in  1  write request
- i_wr_data  in  DataWidth  write word
- i_rd_en  in  1  read (pop) request
- i_clr_err  in  1  clears the sticky error flags
- o_rd_data  out  DataWidth  read word
- o_rd_valid  out  1  o_rd_data holds a valid popped word (see Operation)
- o_full  out  1  count == Depth
- o_empty  out  1  count == 0
- o_almost_full  out  1  count ≥ AlmostFullThresh
- o_almost_empty  out  1  count ≤ AlmostEmptyThresh
- o_count  out  CntWidth  current occupancy, 0..Depth
- o_overflow  out  1  sticky: a write was dropped
- o_underflow  out  1  sticky: a read was dropped

## Operation
**Accept rules** (evaluated on pre-edge state):
- rd_ok = i_rd_en & !o_empty.
- wr_ok = i_wr_en & (!o_full | rd_ok). A write while full is accepted only when a read is accepted in the same cycle.
- Empty with both requests: the write is accepted and the read is rejected. No pass-through.

**Pointers:** wr_ptr and rd_ptr run 0..Depth-1 and wrap explicitly from Depth-1 to 0. They must not rely on natural binary overflow.

**Count:** +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.

**Status flags:** all are pure functions of the registered count, with no extra pipeline stage.

**Errors:**
- o_overflow sets on i_wr_en & !wr_ok.
- o_underflow sets on i_rd_en & !rd_ok.
- i_clr_err clears both.
- If a clear and a new error occur in the same cycle, the flag is set (set wins).
- Errors never modify FIFO contents or pointers.

**Fwft = 0:**
- o_rd_data is registered and loads mem[rd_ptr] on the edge where rd_ok.
- It holds its value otherwise, including across rejected reads.
- o_rd_valid = registered rd_ok, i.e. a one-cycle pulse.

**Fwft = 1:**
- o_rd_data = mem[rd_ptr], combinational from the array.
- o_rd_valid = !o_empty.
- i_rd_en acts as an acknowledge: it pops the shown word.

**Memory:** the array is not reset; only the control state is.

## Timing
**Reset (i_rst high at an edge)**, values visible after that edge, regardless of other inputs:
- pointers = 0, o_count = 0
- o_empty = 1, o_full = 0
- o_almost_empty = 1, o_almost_full = 0
- o_overflow = o_underflow = 0
- o_rd_data = 0, o_rd_valid = 0

Reset mid-operation discards all stored words. Writes or reads presented in the reset cycle are ignored and set no error flags.

**Latency:**
- Write to visible: a word written at edge N is counted after N. It appears on o_rd_data after N in FWFT mode, or after the edge of a subsequent read in registered mode.
- Registered read: read request at edge N gives o_rd_data valid after N, i.e. the same cycle the testbench samples following that edge.

**Throughput:** one write and one read per cycle sustained, including at full and empty boundaries under simultaneous accepted read+write.

**Wrap-around:** the pointer at Depth-1 followed by an accepted operation goes to 0. For Depth = 6, the sequence is 0,1,2,3,4,5,0.

## Test plan
All scenarios use Depth = 6, DataWidth = 8, AlmostFullThresh = 5, AlmostEmptyThresh = 1.

1. **Reset:**
   - Stimulus: assert i_rst with i_wr_en = 1 and i_rd_en = 1.
   - Response: o_count = 0, o_empty = 1, o_almost_empty = 1, o_full = 0, errors 0, o_rd_data = 0.
2. **Fill and drain (Fwft = 0):**
   - Stimulus: write 0x11..0x66, then a 7th write of 0x77 while full; then 6 reads.
   - Response: o_full = 1 and o_count = 6 after the 6th write; o_almost_full = 1 from count 5; 0x77 is dropped and o_overflow = 1.
   - Reads return 0x11..0x66 in order, each with a one-cycle o_rd_valid pulse; o_almost_empty = 1 at count ≤ 1.
   - A 7th read sets o_underflow = 1 and leaves o_rd_data at 0x66.
3. **Wrap-around:**
   - Stimulus: write 4, read 4, write 6 (0xA0..0xA5), read 6.
   - Response: data returned in order 0xA0..0xA5 with no corruption across the pointer wrap at index 5→0.
4. **Simultaneous read/write:**
   - At full: read+write each cycle for 10 cycles. Required: o_count stays 6, o_full stays 1, no overflow, output order preserved.
   - At empty: read+write. Required: the write is accepted, o_count = 1, o_underflow = 1.
5. **FWFT mode (Fwft = 1):**
   - Stimulus: write 0x5A to an empty FIFO.
   - Response: after that edge o_rd_data = 0x5A and o_rd_valid = 1 with no read issued. An i_rd_en pulse pops it; o_empty = 1 and o_rd_valid = 0 on the next cycle.
6. **Error clear priority:**
   - Stimulus: i_clr_err together with a write-while-full.
   - Response: o_overflow remains 1.
   - Then: i_clr_err alone. Response: both error flags go to 0 on the next cycle.
